lcd_write_ctrl: RTL and testbench

- Hardware write sequencer for the HD44780-style character LCD. It sits downstream of the core's LSU LCD output register (o_io_lcd).
- Software posts a command or data byte by writing the register with a toggled request bit.
- The block buffers posted writes in a small FIFO and generates the LCD bus timing: RS/DATA setup, EN pulse, hold, and execution wait. Firmware no longer bit-bangs EN and no longer needs software delay loops.

---
 rtl/lcd_write_ctrl_if.sv | 11 +
 rtl/lcd_write_ctrl.sv | 147 ++++++++++++++
 tb/tb_lcd_write_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_ctrl_if.sv
// LCD bus bundle between the write sequencer (master) and the panel (slave).
interface lcd_write_ctrl_if;
    logic       o_lcd_on;
    logic       o_lcd_en;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic [7:0] o_lcd_data;

    modport master (output o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data);
    modport slave  (input  o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data);
endinterface

// File: rtl/lcd_write_ctrl.sv
// HD44780-style LCD write sequencer: buffers toggle-posted register writes in a
// FIFO and generates RS/DATA setup, EN pulse, hold and execution wait timing.
module lcd_write_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned T_PWRUP    = 750000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN       = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_EXEC     = 2000,
    parameter int unsigned T_CLEAR    = 82000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_lcd_reg,
    lcd_write_ctrl_if.master lcd,
    output logic             o_busy,
    output logic             o_full,
    output logic             o_ovf
);
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned T_MAX = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_limit;
    logic          cnt_done;

    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [8:0]    head;
    logic          fifo_empty;
    logic          req_prev;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          is_clear;

    logic          lcd_on;
    logic          lcd_en;
    logic          lcd_rs;
    logic [7:0]    lcd_data;

    logic          unused_reg_bits;
    assign unused_reg_bits = ^{i_lcd_reg[30:12], i_lcd_reg[10], i_lcd_reg[8]};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign o_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign push_req   = i_lcd_reg[11] ^ req_prev;
    assign pop        = !fifo_empty && ((state == ST_IDLE) || (state == ST_WAIT && cnt_done));
    // A pop on the same edge frees the slot, so a push on a full FIFO still lands.
    assign push       = push_req && (!o_full || pop);
    assign is_clear   = !lcd_rs && (lcd_data[7:1] == 7'b0000000);
    assign o_busy     = ((state != ST_IDLE) && (state != ST_PWRUP)) || !fifo_empty;

    always_comb begin
        cnt_limit = '0;
        case (state)
            ST_PWRUP: cnt_limit = CW'(T_PWRUP - 1);
            ST_SETUP: cnt_limit = CW'(T_SETUP - 1);
            ST_PULSE: cnt_limit = CW'(T_EN - 1);
            ST_HOLD:  cnt_limit = CW'(T_HOLD - 1);
            ST_WAIT:  cnt_limit = is_clear ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
            default:  cnt_limit = '0;
        endcase
    end
    assign cnt_done = (cnt == cnt_limit);

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {i_lcd_reg[9], i_lcd_reg[7:0]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            req_prev <= 1'b0;
            lcd_on   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            req_prev <= i_lcd_reg[11];
            lcd_on   <= i_lcd_reg[31];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push) o_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_PWRUP;
            cnt      <= '0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            cnt <= cnt_done ? '0 : cnt + 1'b1;
            case (state)
                ST_PWRUP: if (cnt_done) state <= ST_IDLE;
                ST_IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        state    <= ST_SETUP;
                        lcd_rs   <= head[8];
                        lcd_data <= head[7:0];
                    end
                end
                ST_SETUP: if (cnt_done) begin
                    state  <= ST_PULSE;
                    lcd_en <= 1'b1;
                end
                ST_PULSE: if (cnt_done) begin
                    state  <= ST_HOLD;
                    lcd_en <= 1'b0;
                end
                ST_HOLD: if (cnt_done) state <= ST_WAIT;
                ST_WAIT: if (cnt_done) begin
                    if (pop) begin
                        state    <= ST_SETUP;
                        lcd_rs   <= head[8];
                        lcd_data <= head[7:0];
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_PWRUP;
            endcase
        end
    end

    assign lcd.o_lcd_on   = lcd_on;
    assign lcd.o_lcd_en   = lcd_en;
    assign lcd.o_lcd_rs   = lcd_rs;
    assign lcd.o_lcd_rw   = 1'b0;
    assign lcd.o_lcd_data = lcd_data;
endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Bench for lcd_write_ctrl: queue/timestamp reference model checked every cycle,
// a vector table for the ON pass-through, and directed multi-cycle sequences.
module tb_lcd_write_ctrl;
    localparam int unsigned DEPTH = 4, TPW = 10, TS = 2, TE = 4, TH = 2, TX = 20, TC = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lcd_reg = '0;
    logic        busy, full, ovf;

    lcd_write_ctrl_if lcd ();

    lcd_write_ctrl #(
        .FIFO_DEPTH(DEPTH), .T_PWRUP(TPW), .T_SETUP(TS), .T_EN(TE),
        .T_HOLD(TH), .T_EXEC(TX), .T_CLEAR(TC)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_lcd_reg(lcd_reg), .lcd(lcd),
        .o_busy(busy), .o_full(full), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: controller is free from m_free_at and takes the oldest
    // entry pushed on an earlier edge; each transaction occupies a fixed span.
    int unsigned edge_n = 0;
    logic [8:0]  m_q[$];
    int unsigned m_free_at = 0, m_last_pop = 0, m_len = 0;
    bit          m_has_pop = 0, m_ovf = 0, m_on = 0, m_req_prev = 0, model_live = 0;
    logic [8:0]  m_cur = '0;

    function automatic int unsigned txn_len(input logic [8:0] e);
        return TS + TE + TH + ((e[8] == 1'b0 && e[7:1] == 7'd0) ? TC : TX);
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_on = 0; m_req_prev = 0; m_has_pop = 0; m_cur = '0;
            m_free_at = edge_n + TPW + 1;
            model_live = 1;
        end else if (model_live) begin
            if (edge_n >= m_free_at && m_q.size() > 0) begin
                m_cur      = m_q.pop_front();
                m_last_pop = edge_n;
                m_len      = txn_len(m_cur);
                m_free_at  = edge_n + m_len;
                m_has_pop  = 1;
            end
            if (lcd_reg[11] != m_req_prev) begin
                if (m_q.size() < DEPTH) m_q.push_back({lcd_reg[9], lcd_reg[7:0]});
                else m_ovf = 1;
            end
            m_req_prev = lcd_reg[11];
            m_on       = lcd_reg[31];
        end
    end

    // Per-cycle comparison plus EN-rise monitor.
    bit          en_q = 0;
    int unsigned rises = 0;
    logic [8:0]  rise_q[$];
    int unsigned rise_e[$];

    always @(negedge clk) begin
        if (model_live) begin
            bit exp_en, exp_busy;
            exp_en   = m_has_pop && (edge_n >= m_last_pop + TS) && (edge_n < m_last_pop + TS + TE);
            exp_busy = (m_has_pop && edge_n < m_last_pop + m_len) || (m_q.size() != 0);
            chk("m_en",   32'(lcd.o_lcd_en), 32'(exp_en));
            chk("m_rs",   32'(lcd.o_lcd_rs), 32'(m_cur[8]));
            chk("m_data", 32'(lcd.o_lcd_data), 32'(m_cur[7:0]));
            chk("m_on",   32'(lcd.o_lcd_on), 32'(m_on));
            chk("m_rw",   32'(lcd.o_lcd_rw), 32'd0);
            chk("m_busy", 32'(busy), 32'(exp_busy));
            chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("m_ovf",  32'(ovf), 32'(m_ovf));
            if (lcd.o_lcd_en === 1'b1 && !en_q) begin
                rises++;
                rise_q.push_back({lcd.o_lcd_rs, lcd.o_lcd_data});
                rise_e.push_back(edge_n);
            end
            en_q = (lcd.o_lcd_en === 1'b1);
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lcd_reg[11] = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic post(input bit rs, input logic [7:0] data);
        lcd_reg[11]  = ~lcd_reg[11];
        lcd_reg[9]   = rs;
        lcd_reg[7:0] = data;
        tick(1);
    endtask

    task automatic wait_rises(input int unsigned target, input int unsigned bound, output bit ok);
        int unsigned n = 0;
        while (rises < target && n < bound) begin
            tick(1);
            n++;
        end
        ok = (rises >= target);
    endtask

    task automatic wait_idle(input string name, input int unsigned bound);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick(1);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [31:0] reg_val;
        bit          exp_on;
        bit          exp_busy;
        bit          exp_en;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int unsigned b, n;

        vecs[0] = '{32'h8000_00FF, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0012, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0200, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFF_F7FF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_F7FF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0841, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        tick(3);

        // Reset state
        do_reset();
        chk("rst_en", 32'(lcd.o_lcd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_data", 32'(lcd.o_lcd_data), 32'd0);

        // Single data write
        tick(TPW + 2);
        lcd_reg[31] = 1'b1;
        b = rises;
        post(1'b1, 8'h41);
        wait_rises(b + 1, 20, ok);
        chk("t1_rise", 32'(ok), 32'd1);
        if (ok) begin
            chk("t1_rsdata", 32'(rise_q[b]), 32'h141);
            n = 1;
            while (lcd.o_lcd_en === 1'b1 && n < 20) begin
                tick(1);
                if (lcd.o_lcd_en === 1'b1) n++;
            end
            chk("t1_en_width", n, TE);
            while (busy === 1'b1 && edge_n < rise_e[b] + 60) tick(1);
            chk("t1_busy_fall", edge_n - (rise_e[b] - TS), 28);
        end

        // Clear command stretches WAIT; normal command does not
        do_reset();
        tick(TPW + 2);
        b = rises;
        post(1'b0, 8'h01);
        post(1'b1, 8'h41);
        wait_rises(b + 2, 200, ok);
        chk("t2_clear_rises", 32'(ok), 32'd1);
        if (ok) chk("t2_clear_spacing", rise_e[b + 1] - rise_e[b], 58);
        wait_idle("t2_idle_a", 200);
        b = rises;
        post(1'b0, 8'h38);
        post(1'b1, 8'h42);
        wait_rises(b + 2, 200, ok);
        chk("t2_exec_rises", 32'(ok), 32'd1);
        if (ok) chk("t2_exec_spacing", rise_e[b + 1] - rise_e[b], 28);
        wait_idle("t2_idle_b", 200);

        // Burst of 6 during power-up: 4 kept, overflow flagged
        do_reset();
        b = rises;
        for (int i = 0; i < 6; i++) begin
            post(1'b1, 8'(8'h10 + i));
            if (i == 2) chk("t3_not_full", 32'(full), 32'd0);
            if (i == 3) begin
                chk("t3_full", 32'(full), 32'd1);
                chk("t3_no_ovf_yet", 32'(ovf), 32'd0);
            end
            if (i == 4) chk("t3_ovf", 32'(ovf), 32'd1);
        end
        wait_rises(b + 4, 300, ok);
        chk("t3_rises", 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 32'(rise_q[b + i]), 32'(9'h110 + i));
            for (int i = 1; i < 4; i++) chk("t3_gap", rise_e[b + i] - rise_e[b + i - 1], 28);
        end
        tick(60);
        chk("t3_total", rises - b, 4);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);

        // Push on full with simultaneous pop at end of power-up
        do_reset();
        b = rises;
        for (int i = 0; i < 4; i++) post(1'b1, 8'(8'h20 + i));
        tick(TPW - 4);
        post(1'b1, 8'h24);
        chk("t4_no_ovf", 32'(ovf), 32'd0);
        chk("t4_full", 32'(full), 32'd1);
        wait_rises(b + 5, 300, ok);
        chk("t4_rises", 32'(ok), 32'd1);
        if (ok) chk("t4_last", 32'(rise_q[b + 4]), 32'h124);
        tick(60);
        chk("t4_total", rises - b, 5);

        // Reset in the second cycle of PULSE
        do_reset();
        tick(TPW + 2);
        b = rises;
        post(1'b1, 8'h55);
        post(1'b1, 8'h66);
        post(1'b1, 8'h77);
        wait_rises(b + 1, 20, ok);
        chk("t5_rise", 32'(ok), 32'd1);
        tick(1);
        rst = 1'b1;
        lcd_reg[11] = 1'b0;
        tick(1);
        chk("t5_en", 32'(lcd.o_lcd_en), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_full", 32'(full), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        b = rises;
        tick(10);
        chk("t5_quiet10", rises - b, 0);
        tick(60);
        chk("t5_discarded", rises - b, 0);

        // ON pass-through without toggles, then one toggle
        do_reset();
        tick(TPW + 2);
        foreach (vecs[i]) begin
            lcd_reg = vecs[i].reg_val;
            tick(1);
            chk("t6_on", 32'(lcd.o_lcd_on), 32'(vecs[i].exp_on));
            chk("t6_busy", 32'(busy), 32'(vecs[i].exp_busy));
            chk("t6_en", 32'(lcd.o_lcd_en), 32'(vecs[i].exp_en));
        end
        wait_idle("t6_idle", 100);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int unsigned pct;
            pct = (i / 500 % 3 == 0) ? 2 : ((i / 500 % 3 == 1) ? 10 : 60);
            rst = ($urandom_range(0, 599) == 0);
            lcd_reg[30:12] = 19'($urandom);
            lcd_reg[10] = 1'($urandom);
            lcd_reg[8]  = 1'($urandom);
            if ($urandom_range(0, 99) < pct) begin
                lcd_reg[11] = ~lcd_reg[11];
                lcd_reg[9]  = 1'($urandom_range(0, 1));
                lcd_reg[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) lcd_reg[31] = ~lcd_reg[31];
            tick(1);
        end
        rst = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
